// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - shared AXI4-Lite response codes and write-arbiter state encoding
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        WAIT_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester grant select; AXI4L_WR_ARB_RR_EN selects round-robin, else fixed priority
module rr_arbiter2 (
    input  logic [1:0] req,
`ifdef AXI4L_WR_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic       grant_idx
);

`ifdef AXI4L_WR_ARB_RR_EN
    // On contention the requester that was not served last wins.
    always_comb begin
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req[1] & ~req[0];
        end
    end
`else
    assign grant_idx = req[1] & ~req[0];
`endif

endmodule

// File: rtl/axi4l_wr_arbiter.sv
// rtl/axi4l_wr_arbiter.sv - two-to-one AXI4-Lite write-channel arbiter; grant held through B
// AXI4L_WR_ARB_RR_EN defined selects round-robin arbitration, otherwise master 0 has fixed priority.
module axi4l_wr_arbiter
    import axi4l_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      i_axi_clock,
    input  logic                      i_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] i_s0_awaddr,
    input  logic [2:0]                i_s0_awprot,
    input  logic                      i_s0_awaddr_valid,
    output logic                      o_s0_awaddr_ready,
    input  logic [AXI_DATA_WIDTH-1:0] i_s0_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] i_s0_wstrb,
    input  logic                      i_s0_wdata_valid,
    output logic                      o_s0_wdata_ready,
    output logic [1:0]                o_s0_bresp,
    output logic                      o_s0_bvalid,
    input  logic                      i_s0_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] i_s1_awaddr,
    input  logic [2:0]                i_s1_awprot,
    input  logic                      i_s1_awaddr_valid,
    output logic                      o_s1_awaddr_ready,
    input  logic [AXI_DATA_WIDTH-1:0] i_s1_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] i_s1_wstrb,
    input  logic                      i_s1_wdata_valid,
    output logic                      o_s1_wdata_ready,
    output logic [1:0]                o_s1_bresp,
    output logic                      o_s1_bvalid,
    input  logic                      i_s1_bready,
    output logic [AXI_ADDR_WIDTH-1:0] o_m_awaddr,
    output logic [2:0]                o_m_awprot,
    output logic                      o_m_awaddr_valid,
    input  logic                      i_m_awaddr_ready,
    output logic [AXI_DATA_WIDTH-1:0] o_m_wdata,
    output logic [AXI_STRB_WIDTH-1:0] o_m_wstrb,
    output logic                      o_m_wdata_valid,
    input  logic                      i_m_wdata_ready,
    input  logic [1:0]                i_m_bresp,
    input  logic                      i_m_bvalid,
    output logic                      o_m_bready,
    output logic [1:0]                o_grant
);

    arb_state_t state, state_nxt;
    logic       gidx, gidx_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;
    logic [1:0] req;
    logic       win;
`ifdef AXI4L_WR_ARB_RR_EN
    logic       last_grant, last_grant_nxt;
`endif

    logic                      sel_awv, sel_wv, sel_bready;
    logic [AXI_ADDR_WIDTH-1:0] sel_awaddr;
    logic [2:0]                sel_awprot;
    logic [AXI_DATA_WIDTH-1:0] sel_wdata;
    logic [AXI_STRB_WIDTH-1:0] sel_wstrb;
    logic                      in_xfer, in_wait_b;
    logic                      aw_rdy, w_rdy, b_vld;
    logic                      aw_hs, w_hs, b_hs;

    assign req = {i_s1_awaddr_valid | i_s1_wdata_valid, i_s0_awaddr_valid | i_s0_wdata_valid};

    rr_arbiter2 u_arb (
        .req        (req),
`ifdef AXI4L_WR_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant_idx  (win)
    );

    assign sel_awv    = gidx ? i_s1_awaddr_valid : i_s0_awaddr_valid;
    assign sel_awaddr = gidx ? i_s1_awaddr       : i_s0_awaddr;
    assign sel_awprot = gidx ? i_s1_awprot       : i_s0_awprot;
    assign sel_wv     = gidx ? i_s1_wdata_valid  : i_s0_wdata_valid;
    assign sel_wdata  = gidx ? i_s1_wdata        : i_s0_wdata;
    assign sel_wstrb  = gidx ? i_s1_wstrb        : i_s0_wstrb;
    assign sel_bready = gidx ? i_s1_bready       : i_s0_bready;

    assign in_xfer   = (state == XFER);
    assign in_wait_b = (state == WAIT_B);

    // Each channel goes quiet once its handshake is done so a held valid cannot repeat it.
    assign o_m_awaddr_valid = in_xfer & ~aw_done & sel_awv;
    assign o_m_awaddr       = o_m_awaddr_valid ? sel_awaddr : '0;
    assign o_m_awprot       = o_m_awaddr_valid ? sel_awprot : 3'b000;
    assign o_m_wdata_valid  = in_xfer & ~w_done & sel_wv;
    assign o_m_wdata        = o_m_wdata_valid ? sel_wdata : '0;
    assign o_m_wstrb        = o_m_wdata_valid ? sel_wstrb : '0;
    assign o_m_bready       = in_wait_b & sel_bready;

    assign aw_rdy = in_xfer & ~aw_done & i_m_awaddr_ready;
    assign w_rdy  = in_xfer & ~w_done & i_m_wdata_ready;
    assign b_vld  = in_wait_b & i_m_bvalid;

    assign o_s0_awaddr_ready = aw_rdy & ~gidx;
    assign o_s1_awaddr_ready = aw_rdy & gidx;
    assign o_s0_wdata_ready  = w_rdy & ~gidx;
    assign o_s1_wdata_ready  = w_rdy & gidx;
    assign o_s0_bvalid       = b_vld & ~gidx;
    assign o_s1_bvalid       = b_vld & gidx;
    assign o_s0_bresp        = (in_wait_b & ~gidx) ? i_m_bresp : RESP_OKAY;
    assign o_s1_bresp        = (in_wait_b & gidx) ? i_m_bresp : RESP_OKAY;
    assign o_grant           = (state == IDLE) ? 2'b00 : {gidx, ~gidx};

    assign aw_hs = o_m_awaddr_valid & i_m_awaddr_ready;
    assign w_hs  = o_m_wdata_valid & i_m_wdata_ready;
    assign b_hs  = i_m_bvalid & o_m_bready;

    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            state      <= IDLE;
            gidx       <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
`ifdef AXI4L_WR_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            gidx       <= gidx_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
`ifdef AXI4L_WR_ARB_RR_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        gidx_nxt       = gidx;
        aw_done_nxt    = aw_done;
        w_done_nxt     = w_done;
`ifdef AXI4L_WR_ARB_RR_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    gidx_nxt    = win;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = XFER;
                end
            end
            XFER: begin
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_done_nxt && w_done_nxt) begin
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (b_hs) begin
`ifdef AXI4L_WR_ARB_RR_EN
                    last_grant_nxt = gidx;
`endif
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/axi4l_wr_arbiter.md
# axi4l_wr_arbiter

Two-to-one AXI4-Lite write-channel arbiter. It shares a single downstream AXI4-Lite slave write port (AW/W/B), normally the register block's write channel, between two upstream masters. It grants one master per transaction and forwards that master's AW, W and B handshakes unchanged. The grant is held until the B handshake completes, so write transactions never interleave.

## Interface
- AXI_DATA_WIDTH, 32, data width in bits
- AXI_ADDR_WIDTH, 4, address width in bits
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width
- i_axi_clock  input  1  clock; all logic on rising edge
- i_axi_aresetn  input  1  reset, asynchronous, active-low
- i_s0_awaddr, i_s1_awaddr  input  AXI_ADDR_WIDTH  upstream write address
- i_s0_awprot, i_s1_awprot  input  3  upstream protection bits
- i_s0_awaddr_valid, i_s1_awaddr_valid  input  1  AW valid
- o_s0_awaddr_ready, o_s1_awaddr_ready  output  1  AW ready
- i_s0_wdata, i_s1_wdata  input  AXI_DATA_WIDTH  write data
- i_s0_wstrb, i_s1_wstrb  input  AXI_STRB_WIDTH  byte strobes
- i_s0_wdata_valid, i_s1_wdata_valid  input  1  W valid
- o_s0_wdata_ready, o_s1_wdata_ready  output  1  W ready
- o_s0_bresp, o_s1_bresp  output  2  write response
- o_s0_bvalid, o_s1_bvalid  output  1  B valid
- i_s0_bready, i_s1_bready  input  1  B ready
- o_m_awaddr / o_m_awprot / o_m_awaddr_valid  output  ADDR/3/1  downstream AW
- i_m_awaddr_ready  input  1  downstream AW ready
- o_m_wdata / o_m_wstrb / o_m_wdata_valid  output  DATA/STRB/1  downstream W
- i_m_wdata_ready  input  1  downstream W ready
- i_m_bresp / i_m_bvalid  input  2/1  downstream B
- o_m_bready  output  1  downstream B ready
- o_grant  output  2  one-hot current grant; 2'b00 when idle

## Operation
- Request for master n: i_sn_awaddr_valid | i_sn_wdata_valid.
- Registered state with three states: IDLE, XFER, WAIT_B. Registered grant index, aw_done and w_done flags, and last_grant pointer.
- IDLE: if any request is present, select a winner, set the grant, clear both done flags, and go to XFER. Otherwise stay in IDLE.
- XFER: the granted master's AW and W signals are routed combinationally to the downstream port, and downstream readies are routed back to that master.
  - A downstream AW handshake sets aw_done and forces o_m_awaddr_valid and that master's ready to 0 afterwards. W behaves the same with w_done.
  - When both handshakes are complete (including both in the same cycle, or the second one this cycle), go to WAIT_B.
- WAIT_B: route i_m_bresp and i_m_bvalid to the granted master and its i_sn_bready to o_m_bready. On the B handshake, set last_grant to the granted index, clear the grant, and go to IDLE.
- Master not granted: its readies and bvalid are 0 and its bresp is 2'b00. Its requests are held pending, and AXI requires the master to keep valid asserted.
- Outside WAIT_B: o_m_bready is 0, and downstream bvalid is ignored.
- All downstream outputs are 0 in IDLE. Data and address are zeroed when not routed.

## Timing
- Reset values: every output is 0, state is IDLE, last_grant is 1 (so master 0 wins first).
- Arbitration latency: a request seen in IDLE on cycle N is forwarded downstream starting at cycle N+1.
- Forwarding adds zero latency: downstream handshakes complete in the same cycle as upstream ones.
- Minimum transaction length is 3 cycles (IDLE, XFER, WAIT_B). A new grant can occur in the cycle after the B handshake, via IDLE.
- No valid depends combinationally on a ready.
- Reset asserted mid-transaction: immediate return to IDLE, flags and grant cleared, pointer reset. Any downstream transaction in flight is abandoned.

## Configuration
- AXI4L_WR_ARB_RR_EN defined: round-robin. When both masters request in IDLE, the one that is not last_grant wins.
- Not defined: fixed priority. Master 0 always wins a simultaneous request, and last_grant is unused.

## Structure
- Shared package axi4l_pkg: response constants (RESP_OKAY 2'b00, RESP_SLVERR 2'b10) and the arbiter state encoding (IDLE, XFER, WAIT_B).
- Sub-module rr_arbiter2: combinational two-requester grant from the request vector and last_grant, with the RR/fixed mode selected by the macro.

## Test plan
- Master 0 only: awaddr 4'h4, wdata 32'hDEADBEEF, wstrb 4'hF, downstream ready.
  - Downstream sees those values at cycle N+1.
  - Bresp 2'b00 is returned on s0 only, and o_grant is 01 then 00.
- Both request in the same cycle after reset: master 0 is served first, then master 1 (RR_EN defined).
  - Both requesting again: master 0 is served again in RR mode.
  - Without RR_EN, master 0 wins every time.
- W arrives 3 cycles before AW on master 1: W is handshaken first and W valid then drops.
  - State stays XFER until AW completes, then goes to WAIT_B.
- Downstream holds bvalid with bresp 2'b10 while i_s0_bready stays 0 for 4 cycles: the grant holds, and master 1's readies stay 0 throughout.
- Reset pulse during XFER with aw_done set: all outputs are 0 next cycle. A subsequent request is granted to master 0.
